prng_share_ctrl: RTL and testbench

Sequencing and arbitration controller that owns a single 64-bit LCG core and shares its output stream among `NUM_REQ` requesters. It handles seeding, reseeding and discarding of warm-up values. It then serves one random word per grant in round-robin order. The LCG advances only when a value is consumed or discarded, so the sequence is deterministic for a given seed and consumption order.

---
 rtl/prng_pkg.sv | 18 +
 rtl/lcg_core.sv | 26 ++
 rtl/prng_share_ctrl.sv | 116 +++++++++++
 tb/tb_prng_share_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// Shared constants, FSM state type and LCG step function for the PRNG sharing controller.
package prng_pkg;

  localparam logic [63:0] LCG_MULT = 64'h5851F42D4C957F2D;
  localparam logic [63:0] LCG_INC  = 64'h14057B7EF767814F;

  typedef enum logic [1:0] {
    LOAD,
    WARMUP,
    SERVE
  } prng_state_e;

  // Product and sum both wrap modulo 2^64.
  function automatic logic [63:0] lcg_next(input logic [63:0] state);
    return state * LCG_MULT + LCG_INC;
  endfunction

endpackage

// File: rtl/lcg_core.sv
// 64-bit LCG state register; loads a seed or advances one step when enabled.
module lcg_core
  import prng_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] load_val,
  input  logic        advance,
  output logic [63:0] state,
  output logic [63:0] next
);

  assign next = lcg_next(state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= '0;
    end else if (load) begin
      state <= load_val;
    end else if (advance) begin
      state <= next;
    end
  end

endmodule

// File: rtl/prng_share_ctrl.sv
// Seeds and warms up one LCG, then serves its words to NUM_REQ requesters in round-robin order.
module prng_share_ctrl #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WARMUP  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [63:0]                seed,
  input  logic                       reseed,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       rand_valid,
  output logic [63:0]                rand_data,
  output logic [$clog2(NUM_REQ)-1:0] rand_id,
  output logic                       ready,
  output logic [31:0]                draw_count
);
  import prng_pkg::prng_state_e;
  import prng_pkg::LOAD;
  import prng_pkg::SERVE;

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  prng_state_e     fsm;
  logic [7:0]      warm_cnt;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] win_id;
  logic [ID_W-1:0] cand;
  logic            win_found;
  logic            core_load;
  logic            core_adv;
  logic [63:0]     lcg_nxt;
  logic [63:0]     lcg_state_unused;

  // The core only moves when a word is consumed or discarded; reseed freezes it.
  assign core_load = (fsm == LOAD) && !reseed;
  assign core_adv  = !reseed &&
                     ((fsm == prng_pkg::WARMUP) || ((fsm == SERVE) && win_found));

  lcg_core u_lcg (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (seed),
    .advance  (core_adv),
    .state    (lcg_state_unused),
    .next     (lcg_nxt)
  );

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm        <= LOAD;
      warm_cnt   <= '0;
      ptr        <= '0;
      grant      <= '0;
      rand_valid <= 1'b0;
      rand_data  <= '0;
      rand_id    <= '0;
      ready      <= 1'b0;
      draw_count <= '0;
    end else if (reseed) begin
      fsm        <= LOAD;
      ptr        <= '0;
      grant      <= '0;
      rand_valid <= 1'b0;
      ready      <= 1'b0;
      draw_count <= '0;
    end else begin
      grant      <= '0;
      rand_valid <= 1'b0;
      unique case (fsm)
        LOAD: begin
          warm_cnt <= 8'(WARMUP);
          if (WARMUP != 0) begin
            fsm <= prng_pkg::WARMUP;
          end else begin
            fsm   <= SERVE;
            ready <= 1'b1;
          end
        end
        prng_pkg::WARMUP: begin
          warm_cnt <= warm_cnt - 8'd1;
          if (warm_cnt == 8'd1) begin
            fsm   <= SERVE;
            ready <= 1'b1;
          end
        end
        SERVE: begin
          if (win_found) begin
            grant[win_id] <= 1'b1;
            rand_valid    <= 1'b1;
            rand_data     <= lcg_nxt;
            rand_id       <= win_id;
            draw_count    <= draw_count + 32'd1;
            ptr           <= ID_W'((32'(win_id) + 1) % NUM_REQ);
          end
        end
        default: fsm <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_share_ctrl.sv
// Scoreboard bench for prng_share_ctrl: a WARMUP=4 instance plus a WARMUP=0 instance.
module tb_prng_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] seed, seed0;
  logic        reseed, reseed0;
  logic [3:0]  req, req0;

  logic [3:0]  grant, grant_w0;
  logic        rand_valid, rand_valid_w0;
  logic [63:0] rand_data, rand_data_w0;
  logic [1:0]  rand_id, rand_id_w0;
  logic        ready, ready_w0;
  logic [31:0] draw_count, draw_count_w0;

  always #5 clk = ~clk;

  prng_share_ctrl #(.NUM_REQ(4), .WARMUP(4)) u_dut (
    .clk(clk), .rst(rst), .seed(seed), .reseed(reseed), .req(req),
    .grant(grant), .rand_valid(rand_valid), .rand_data(rand_data),
    .rand_id(rand_id), .ready(ready), .draw_count(draw_count)
  );

  prng_share_ctrl #(.NUM_REQ(4), .WARMUP(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .seed(seed0), .reseed(reseed0), .req(req0),
    .grant(grant_w0), .rand_valid(rand_valid_w0), .rand_data(rand_data_w0),
    .rand_id(rand_id_w0), .ready(ready_w0), .draw_count(draw_count_w0)
  );

  typedef struct {
    logic [1:0]  id;
    logic [63:0] data;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] sb0[$];
  logic [63:0] m_state;
  int unsigned m_ptr;
  logic [31:0] m_cnt;
  logic [63:0] first_word;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [63:0] lcg(input logic [63:0] s);
    return s * 64'h5851F42D4C957F2D + 64'h14057B7EF767814F;
  endfunction

  task automatic model_restart();
    m_state = seed;
    repeat (4) m_state = lcg(m_state);
    m_ptr = 0;
    m_cnt = '0;
    sb.delete();
  endtask

  // Drives req and pushes the expected served word, if any, onto the scoreboard.
  task automatic drive_req(input logic [3:0] v);
    exp_t        e;
    logic [1:0]  j;
    bit          hit;
    int unsigned w;
    req = v;
    hit = 1'b0;
    w   = 0;
    for (int unsigned k = 0; k < 4; k++) begin
      j = 2'((m_ptr + k) % 4);
      if (!hit && v[j]) begin
        hit = 1'b1;
        w   = 32'(j);
      end
    end
    if (hit) begin
      m_state = lcg(m_state);
      m_cnt   = m_cnt + 32'd1;
      m_ptr   = (w + 1) % 4;
      e.id    = 2'(w);
      e.data  = m_state;
      e.cnt   = m_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; reseed = 1'b0; req = '0; seed = 64'h1;
    reseed0 = 1'b0; req0 = '0; seed0 = 64'h0;
    #12;
    n_tests++;
    if ({grant, rand_valid, ready, rand_data, rand_id, draw_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b valid=%b ready=%b data=%h id=%0d cnt=%0d, want all 0",
               grant, rand_valid, ready, rand_data, rand_id, draw_count);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (ready !== (k == 5)) begin
        n_fail++;
        $display("FAIL ready_timing edge %0d: ready=%b want %b", k, ready, k == 5);
      end
      if (k == 1) begin
        n_tests++;
        if (ready_w0 !== 1'b1) begin
          n_fail++;
          $display("FAIL w0_ready: ready=%b want 1", ready_w0);
        end
      end
    end
    model_restart();
  endtask

  task automatic test_first_word();
    exp_t e;
    drive_req(4'b0001);
    @(posedge clk); #1;
    e = sb.pop_front();
    first_word = e.data;
    n_tests++;
    if (rand_valid !== 1'b1 || rand_data !== e.data || rand_id !== e.id ||
        grant !== 4'b0001 || draw_count !== e.cnt) begin
      n_fail++;
      $display("FAIL first_word: valid=%b id=%0d data=%h grant=%b cnt=%0d, want id=%0d data=%h grant=0001 cnt=%0d",
               rand_valid, rand_id, rand_data, grant, draw_count, e.id, e.data, e.cnt);
    end
    drive_req(4'b0000);
    @(posedge clk); #1;
    n_tests++;
    if (rand_valid !== 1'b0 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_no_grant: valid=%b grant=%b want 0/0000", rand_valid, grant);
    end
  endtask

  task automatic test_reseed();
    reseed = 1'b1;
    req    = 4'b1111;
    @(posedge clk); #1;
    reseed = 1'b0;
    n_tests++;
    if (grant !== 4'b0000 || rand_valid !== 1'b0 || ready !== 1'b0 || draw_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reseed_cycle: grant=%b valid=%b ready=%b cnt=%0d, want 0000/0/0/0",
               grant, rand_valid, ready, draw_count);
    end
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (rand_valid !== 1'b0 || ready !== (k == 5)) begin
        n_fail++;
        $display("FAIL reseed_warmup edge %0d: valid=%b ready=%b, want 0/%b", k, rand_valid, ready, k == 5);
      end
    end
    model_restart();
  endtask

  task automatic test_round_robin();
    exp_t       e;
    logic [3:0] exp_grant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      drive_req(4'b1111);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (rand_valid !== 1'b1 || rand_data !== e.data || rand_id !== e.id ||
          grant !== exp_grant[i] || draw_count !== e.cnt) begin
        n_fail++;
        $display("FAIL rr_word%0d: valid=%b id=%0d data=%h grant=%b cnt=%0d, want id=%0d data=%h grant=%b cnt=%0d",
                 i, rand_valid, rand_id, rand_data, grant, draw_count, e.id, e.data, exp_grant[i], e.cnt);
      end
      if (i == 0) begin
        n_tests++;
        if (rand_data !== first_word) begin
          n_fail++;
          $display("FAIL reseed_repeat: data=%h want %h", rand_data, first_word);
        end
      end
    end
    n_tests++;
    if (draw_count !== 32'd5) begin
      n_fail++;
      $display("FAIL rr_count: cnt=%0d want 5", draw_count);
    end
    drive_req(4'b0000);
    @(posedge clk); #1;
  endtask

  task automatic test_lone_requester();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive_req(4'b0100);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (rand_valid !== 1'b1 || rand_data !== e.data || rand_id !== 2'd2 ||
          grant !== 4'b0100 || draw_count !== e.cnt) begin
        n_fail++;
        $display("FAIL lone_word%0d: valid=%b id=%0d data=%h grant=%b cnt=%0d, want id=2 data=%h grant=0100 cnt=%0d",
                 i, rand_valid, rand_id, rand_data, grant, draw_count, e.data, e.cnt);
      end
    end
    drive_req(4'b0000);
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    exp_t e;
    force u_dut.draw_count = 32'hFFFFFFFF;
    #1;
    release u_dut.draw_count;
    m_cnt = 32'hFFFFFFFF;
    for (int i = 0; i < 2; i++) begin
      drive_req(4'b0010);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (rand_valid !== 1'b1 || rand_data !== e.data || rand_id !== 2'd1 ||
          draw_count !== 32'(i)) begin
        n_fail++;
        $display("FAIL wrap%0d: valid=%b id=%0d data=%h cnt=%h, want id=1 data=%h cnt=%h",
                 i, rand_valid, rand_id, rand_data, draw_count, e.data, 32'(i));
      end
    end
    drive_req(4'b0000);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    drive_req(4'b1111);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_tests++;
    if (rand_valid !== 1'b1 || rand_data !== e.data || rand_id !== e.id) begin
      n_fail++;
      $display("FAIL pre_reset_word: valid=%b id=%0d data=%h, want id=%0d data=%h",
               rand_valid, rand_id, rand_data, e.id, e.data);
    end
    #2;
    rst = 1'b0;
    #1;
    n_tests++;
    if ({grant, rand_valid, ready, rand_data, rand_id, draw_count,
         grant_w0, rand_valid_w0, ready_w0, rand_data_w0, rand_id_w0, draw_count_w0} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: grant=%b valid=%b ready=%b data=%h id=%0d cnt=%0d w0_ready=%b, want all 0",
               grant, rand_valid, ready, rand_data, rand_id, draw_count, ready_w0);
    end
    model_restart();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (rand_valid !== 1'b0 || ready !== (k == 5)) begin
        n_fail++;
        $display("FAIL restart_warmup edge %0d: valid=%b ready=%b, want 0/%b", k, rand_valid, ready, k == 5);
      end
    end
    drive_req(4'b1111);
    @(posedge clk); #1;
    e = sb.pop_front();
    n_tests++;
    if (rand_valid !== 1'b1 || rand_data !== first_word || grant !== 4'b0001 || draw_count !== 32'd1) begin
      n_fail++;
      $display("FAIL restart_word: valid=%b data=%h grant=%b cnt=%0d, want data=%h grant=0001 cnt=1",
               rand_valid, rand_data, grant, draw_count, first_word);
    end
    drive_req(4'b0000);
    @(posedge clk); #1;
  endtask

  task automatic test_warmup0();
    logic [63:0] m0;
    logic [63:0] want;
    m0 = seed0;
    req0 = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      m0 = lcg(m0);
      sb0.push_back(m0);
      @(posedge clk); #1;
      want = sb0.pop_front();
      n_tests++;
      if (rand_valid_w0 !== 1'b1 || rand_data_w0 !== want || rand_id_w0 !== 2'd0 ||
          grant_w0 !== 4'b0001 || draw_count_w0 !== 32'(i + 1)) begin
        n_fail++;
        $display("FAIL w0_word%0d: valid=%b id=%0d data=%h grant=%b cnt=%0d, want id=0 data=%h grant=0001 cnt=%0d",
                 i, rand_valid_w0, rand_id_w0, rand_data_w0, grant_w0, draw_count_w0, want, i + 1);
      end
      if (i == 0) begin
        n_tests++;
        if (rand_data_w0 !== 64'h14057B7EF767814F) begin
          n_fail++;
          $display("FAIL w0_first_const: data=%h want 14057b7ef767814f", rand_data_w0);
        end
      end
    end
    req0 = 4'b0000;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_reseed();
    test_round_robin();
    test_lone_requester();
    test_wrap();
    test_reset_midstream();
    test_warmup0();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
